keyboard_event_ctrl: RTL and testbench

//  Turns the raw PS/2 set-2 byte stream from the keyboard receiver into key events.
//  It strips the E0 (extended), F0 (release) and E1 (pause) prefixes and tracks the

---
 rtl/keyboard_pkg.sv | 31 +++
 rtl/keyboard_event_ctrl_if.sv | 26 ++
 rtl/kbd_event_fifo.sv | 50 +++++
 rtl/keyboard_event_ctrl.sv | 134 +++++++++++++
 tb/tb_keyboard_event_ctrl.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/keyboard_pkg.sv
// Shared scancode constants, event layout and decoder state type for the keyboard
// event controller.
package keyboard_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_REL    = 8'hF0;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;

  // Event word: {release, extended, code[7:0]}
  localparam int unsigned EV_WIDTH    = 10;
  localparam int unsigned EV_CODE_LSB = 0;
  localparam int unsigned EV_EXT_BIT  = 8;
  localparam int unsigned EV_REL_BIT  = 9;

  // Bytes that follow E1 in the pause sequence
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [2:0] {StIdle, StExt, StRel, StExtRel, StSkip} kbd_state_e;

  function automatic logic is_filler(input logic [7:0] code);
    unique case (code)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: is_filler = 1'b1;
      default:                                                 is_filler = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/keyboard_event_ctrl_if.sv
// Byte-in / event-out bundle of the keyboard event controller.
interface keyboard_event_ctrl_if;
  import keyboard_pkg::*;

  logic [7:0]          kb_code;
  logic                kb_strobe;
  logic                event_valid;
  logic [EV_WIDTH-1:0] event_data;
  logic                event_pop;
  logic                mod_shift;
  logic                mod_ctrl;
  logic                mod_alt;
  logic                overflow;
  logic                overflow_clr;

  modport master (
    output kb_code, kb_strobe, event_pop, overflow_clr,
    input  event_valid, event_data, mod_shift, mod_ctrl, mod_alt, overflow
  );

  modport slave (
    input  kb_code, kb_strobe, event_pop, overflow_clr,
    output event_valid, event_data, mod_shift, mod_ctrl, mod_alt, overflow
  );

endinterface

// File: rtl/kbd_event_fifo.sv
// Synchronous first-word-fall-through FIFO; data_out is the head entry whenever !empty.
module kbd_event_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           data_in,
  output logic [WIDTH-1:0]           data_out,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= data_in;
  end

  assign data_out = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/keyboard_event_ctrl.sv
// PS/2 set-2 prefix decoder: strips E0/F0/E1 prefixes, tracks modifiers and queues
// completed key events in a FWFT FIFO.
module keyboard_event_ctrl
  import keyboard_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned PREFIX_TIMEOUT = 2000000
) (
  input  logic                 clock,
  input  logic                 reset,
  keyboard_event_ctrl_if.slave kb
);

  localparam int unsigned TmoW = $clog2(PREFIX_TIMEOUT);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  kbd_state_e          state_q, state_d;
  logic [2:0]          skip_q, skip_d;
  logic [TmoW-1:0]     tmo_q, tmo_d;
  logic                emit, ev_rel, ev_ext;
  logic [7:0]          ev_code;
  logic [EV_WIDTH-1:0] ev_word;
  logic [5:0]          mods_q, mods_d;  // {ralt, lalt, rctrl, lctrl, rshift, lshift}
  logic                overflow_q, overflow_d;
  logic                fifo_full, fifo_empty, push_ok, drop;
  logic [CntW-1:0]     fifo_count;

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    emit    = 1'b0;
    ev_rel  = 1'b0;
    ev_ext  = 1'b0;
    ev_code = kb.kb_code;
    if (kb.kb_strobe) begin
      unique case (state_q)
        StIdle: begin
          if (kb.kb_code == SC_EXT) state_d = StExt;
          else if (kb.kb_code == SC_REL) state_d = StRel;
          else if (kb.kb_code == SC_PAUSE) begin
            state_d = StSkip;
            skip_d  = PAUSE_SKIP;
          end else if (!is_filler(kb.kb_code)) emit = 1'b1;
        end
        StExt: begin
          state_d = (kb.kb_code == SC_REL) ? StExtRel : StIdle;
          if (kb.kb_code != SC_REL && kb.kb_code != SC_EXT && !is_filler(kb.kb_code)) begin
            emit   = 1'b1;
            ev_ext = 1'b1;
          end
        end
        StRel, StExtRel: begin
          state_d = StIdle;
          if (kb.kb_code != SC_REL && kb.kb_code != SC_EXT && !is_filler(kb.kb_code)) begin
            emit   = 1'b1;
            ev_rel = 1'b1;
            ev_ext = (state_q == StExtRel);
          end
        end
        StSkip: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) begin
            state_d = StIdle;
            emit    = 1'b1;
            ev_ext  = 1'b1;
            ev_code = SC_PAUSE;
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle && tmo_q == '0) begin
      state_d = StIdle;
    end

    // The counter only runs while a prefix is pending
    if (state_d == StIdle)  tmo_d = '0;
    else if (kb.kb_strobe)  tmo_d = TmoW'(PREFIX_TIMEOUT - 1);
    else                    tmo_d = tmo_q - 1'b1;
  end

  assign ev_word = {ev_rel, ev_ext, ev_code};

  always_comb begin
    mods_d = mods_q;
    if (emit) begin
      if (!ev_ext && ev_code == SC_LSHIFT) mods_d[0] = !ev_rel;
      if (!ev_ext && ev_code == SC_RSHIFT) mods_d[1] = !ev_rel;
      if (ev_code == SC_CTRL)              mods_d[ev_ext ? 3 : 2] = !ev_rel;
      if (ev_code == SC_ALT)               mods_d[ev_ext ? 5 : 4] = !ev_rel;
    end
  end

  assign push_ok    = emit && (fifo_count < CntW'(FIFO_DEPTH) || kb.event_pop);
  assign drop       = emit && fifo_full && !kb.event_pop;
  assign overflow_d = drop ? 1'b1 : (kb.overflow_clr ? 1'b0 : overflow_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      skip_q     <= '0;
      tmo_q      <= '0;
      mods_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      tmo_q      <= tmo_d;
      mods_q     <= mods_d;
      overflow_q <= overflow_d;
    end
  end

  kbd_event_fifo #(
    .WIDTH (EV_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push_ok),
    .pop      (kb.event_pop),
    .data_in  (ev_word),
    .data_out (kb.event_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign kb.event_valid = !fifo_empty;
  assign kb.mod_shift   = mods_q[0] | mods_q[1];
  assign kb.mod_ctrl    = mods_q[2] | mods_q[3];
  assign kb.mod_alt     = mods_q[4] | mods_q[5];
  assign kb.overflow    = overflow_q;

endmodule

// File: tb/tb_keyboard_event_ctrl.sv
// Directed bench for keyboard_event_ctrl with hand-computed expected events.
module tb_keyboard_event_ctrl;

  localparam int unsigned Depth   = 16;
  localparam int unsigned Timeout = 50;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  keyboard_event_ctrl_if kb_if ();

  keyboard_event_ctrl #(
    .FIFO_DEPTH     (Depth),
    .PREFIX_TIMEOUT (Timeout)
  ) dut (
    .clock (clock),
    .reset (reset),
    .kb    (kb_if.slave)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clock);
    kb_if.kb_code   = b;
    kb_if.kb_strobe = 1'b1;
    @(negedge clock);
    kb_if.kb_strobe = 1'b0;
  endtask

  task automatic send_pop(input logic [7:0] b);
    @(negedge clock);
    kb_if.kb_code   = b;
    kb_if.kb_strobe = 1'b1;
    kb_if.event_pop = 1'b1;
    @(negedge clock);
    kb_if.kb_strobe = 1'b0;
    kb_if.event_pop = 1'b0;
  endtask

  task automatic pop();
    @(negedge clock);
    kb_if.event_pop = 1'b1;
    @(negedge clock);
    kb_if.event_pop = 1'b0;
  endtask

  task automatic expect_event(input string tag, input logic [9:0] exp);
    check_eq({tag, "_valid"}, 16'(kb_if.event_valid), 16'd1);
    check_eq({tag, "_data"}, 16'(kb_if.event_data), 16'(exp));
    pop();
  endtask

  task automatic expect_empty(input string tag);
    check_eq({tag, "_empty"}, 16'(kb_if.event_valid), 16'd0);
  endtask

  initial begin
    kb_if.kb_code      = 8'h1C;
    kb_if.kb_strobe    = 1'b1;  // strobe during reset must be discarded
    kb_if.event_pop    = 1'b0;
    kb_if.overflow_clr = 1'b0;
    repeat (3) @(negedge clock);
    kb_if.kb_strobe = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    check_eq("rst_valid", 16'(kb_if.event_valid), 16'd0);
    check_eq("rst_mods", 16'({kb_if.mod_shift, kb_if.mod_ctrl, kb_if.mod_alt}), 16'd0);
    check_eq("rst_ovf", 16'(kb_if.overflow), 16'd0);

    // Plain make / break, one-cycle latency
    @(negedge clock);
    kb_if.kb_code   = 8'h1C;
    kb_if.kb_strobe = 1'b1;
    check_eq("lat_before", 16'(kb_if.event_valid), 16'd0);
    @(negedge clock);
    kb_if.kb_strobe = 1'b0;
    expect_event("make_1c", 10'h01C);
    expect_empty("make_1c");
    send(8'hF0); send(8'h1C);
    expect_event("break_1c", 10'h21C);

    // Extended codes and right ctrl
    send(8'hE0); send(8'h75);
    expect_event("ext_75", 10'h175);
    send(8'hE0); send(8'hF0); send(8'h75);
    expect_event("extrel_75", 10'h375);
    send(8'hE0); send(8'h14);
    check_eq("rctrl_on", 16'(kb_if.mod_ctrl), 16'd1);
    expect_event("rctrl_ev", 10'h114);
    send(8'hE0); send(8'hF0); send(8'h14);
    check_eq("rctrl_off", 16'(kb_if.mod_ctrl), 16'd0);
    expect_event("rctrl_rel", 10'h314);

    // Shift tracking with two keys and a fake shift
    send(8'h12);
    check_eq("lshift_on", 16'(kb_if.mod_shift), 16'd1);
    send(8'h59);
    check_eq("rshift_on", 16'(kb_if.mod_shift), 16'd1);
    send(8'hF0); send(8'h12);
    check_eq("lshift_off", 16'(kb_if.mod_shift), 16'd1);
    send(8'hF0); send(8'h59);
    check_eq("rshift_off", 16'(kb_if.mod_shift), 16'd0);
    send(8'hE0); send(8'h12);
    check_eq("fake_shift", 16'(kb_if.mod_shift), 16'd0);
    expect_event("sh1", 10'h012);
    expect_event("sh2", 10'h059);
    expect_event("sh3", 10'h212);
    expect_event("sh4", 10'h259);
    expect_event("sh5", 10'h112);

    // Alt: left and right tracked separately
    send(8'h11);
    send(8'hE0); send(8'h11);
    send(8'hF0); send(8'h11);
    check_eq("alt_right_held", 16'(kb_if.mod_alt), 16'd1);
    send(8'hE0); send(8'hF0); send(8'h11);
    check_eq("alt_off", 16'(kb_if.mod_alt), 16'd0);
    repeat (4) pop();
    expect_empty("alt");

    // Pause sequence collapses to one event
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    check_eq("pause_noctrl", 16'(kb_if.mod_ctrl), 16'd0);
    expect_event("pause", 10'h1E1);
    expect_empty("pause");

    // Prefix timeout and filler bytes
    send(8'hE0);
    repeat (Timeout + 5) @(negedge clock);
    send(8'h1C);
    expect_event("timeout", 10'h01C);
    expect_empty("timeout");
    send(8'hAA); send(8'hFA);
    expect_empty("filler");

    // Overflow, push-with-pop at full, overflow clear
    for (int i = 0; i < 16; i++) send(8'h15 + 8'(i));
    check_eq("full_no_ovf", 16'(kb_if.overflow), 16'd0);
    send(8'h30);
    check_eq("ovf_set", 16'(kb_if.overflow), 16'd1);
    check_eq("ovf_head", 16'(kb_if.event_data), 16'h015);
    send_pop(8'h2A);
    check_eq("pushpop_head", 16'(kb_if.event_data), 16'h016);
    @(negedge clock);
    kb_if.overflow_clr = 1'b1;
    @(negedge clock);
    kb_if.overflow_clr = 1'b0;
    check_eq("ovf_clr", 16'(kb_if.overflow), 16'd0);
    for (int i = 1; i < 16; i++) expect_event("drain", 10'(8'h15 + 8'(i)));
    expect_event("drain_last", 10'h02A);
    expect_empty("drain");

    // Reset mid-prefix flushes everything
    send(8'h1C);
    send(8'hE0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    expect_empty("mid_rst");
    send(8'h1C);
    expect_event("post_rst", 10'h01C);
    expect_empty("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
